receiver: RTL and testbench
===========================

Name: receiver

Overview:
- UART receive side paired with the team's 8N1 Transmitter on the same Clock domain.
- Watches the serial line for a start bit, samples 8 data bits LSB-first, then checks (optionally) the stop slot.
- Presents the byte with a one-cycle RxDone strobe.
- Default CLKS_PER_BIT=1 matches the transmitter's one-bit-per-clock line rate; larger values support a divided baud with mid-bit sampling.

Parameters:
- CLKS_PER_BIT, 1, Clock cycles per serial bit; legal range 1..65535. HALF = (CLKS_PER_BIT-1)/2 (integer divide).
- STOP_CHECK, 0, 1 = stop slot must read 1, otherwise flag a framing error; 0 = stop slot sampled but ignored.

Ports:
- Clock  input  1  sole clock, rising edge.
- Reset  input  1  synchronous, active-high.
- RxDataIn  input  1  serial line; idle high; synchronous to Clock (no internal synchronizer).
- RxDataOut  output  8  last received byte; holds until next completed frame.
- RxDone  output  1  one-cycle pulse: RxDataOut updated this cycle.
- RxFrameErr  output  1  one-cycle pulse coincident with RxDone when STOP_CHECK=1 and the stop slot read 0.

Behaviour:
- Reset (sampled at posedge, Reset=1): state=IDLE, RxDataOut=8'h00, RxDone=0, RxFrameErr=0, counters=0. Overrides any in-progress frame; a partial byte is discarded, no RxDone.
- Bit-time counter width is clog2(CLKS_PER_BIT) (minimum 1). Bit index is 3 bits. Shift register is 8 bits, LSB-first: each sampled data bit enters at bit 7 and shifts right.
- All outputs are registered. RxDone and RxFrameErr are 0 in every cycle except the completion cycle.
- IDLE:
  - At the edge k where RxDataIn==0, start detected.
  - If HALF==0, treat edge k as the start mid-sample and go to DATA with counter=0.
  - Otherwise go to START with counter=1.
- START:
  - Counter increments each cycle.
  - At counter==HALF, re-sample. If RxDataIn==0, go to DATA with counter=0. If RxDataIn==1, it is a glitch: return to IDLE with no output activity.
- DATA:
  - Sample data bit j (j=0..7) at edge k+HALF+CLKS_PER_BIT*(j+1).
  - After bit 7, go to STOP.
- STOP:
  - Sample the stop slot at edge k+HALF+9*CLKS_PER_BIT.
  - At that same edge: RxDataOut <= assembled byte and RxDone <= 1.
  - RxFrameErr <= (STOP_CHECK && RxDataIn==0).
- Next state after STOP:
  - If a framing error was flagged, go to WAIT_HIGH.
  - Otherwise go to IDLE.
- WAIT_HIGH: stay until RxDataIn==1, then go to IDLE. This prevents a held-low line (break) from being seen as a new start bit.
- Latency: with CLKS_PER_BIT=1, RxDone is high in the cycle after edge k+9, where k is the edge that first samples the start bit.
- Back-to-back frames:
  - The cycle after the STOP edge, the block is in IDLE and may detect a new start at the very next edge.
  - No idle bit is required between frames beyond the stop slot.
- STOP_CHECK=0: the stop slot value is don't-care. The transmitter's stop cycle may carry the previous data bit, which is legal in this mode.
- RxDataIn changes inside a bit period (CLKS_PER_BIT>1): only the scheduled sample points matter.

Test Plan:
- Reset, then hold RxDataIn=1 for 20 cycles -> RxDone=0, RxFrameErr=0, RxDataOut=8'h00 throughout.
- CLKS_PER_BIT=1, STOP_CHECK=0. Drive from the team Transmitter on a shared Clock: TxDataLoad pulse with TxDataIn=8'hA5 -> exactly one RxDone pulse, RxDataOut=8'hA5, aligned with TxDone ±1 cycle. Repeat back-to-back loads 8'h00, 8'hFF, 8'h3C -> three RxDone pulses, bytes in order.
- CLKS_PER_BIT=4, line driven by bench (start 0 for 4 clocks, bits of 8'h5A LSB-first, 4 clocks each, stop 1) -> RxDone at edge k+1+36, RxDataOut=8'h5A, RxFrameErr=0.
- CLKS_PER_BIT=4: 1-cycle low glitch on an idle line -> START aborts at counter==1, no RxDone, back to IDLE. Then a valid frame 8'h81 -> received correctly.
- CLKS_PER_BIT=4, STOP_CHECK=1: frame 8'hC3 with stop slot low, line held low 10 more cycles, then high -> RxDone and RxFrameErr pulse together with RxDataOut=8'hC3. No second RxDone while low; the next valid frame 8'h11 is received.
- Assert Reset at data bit 4 of a frame, release, then send 8'h7E -> no RxDone for the aborted frame; 8'h7E received, RxDataOut=8'h7E.

Source files
------------

// File: rtl/receiver.sv
// UART 8N1 receive side: start-bit detect, mid-bit sampling of 8 data bits LSB-first,
// optional stop-slot check, and a registered one-cycle completion strobe.
module receiver #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit STOP_CHECK   = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxDataIn,
    output logic [7:0] RxDataOut,
    output logic       RxDone,
    output logic       RxFrameErr
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            RxDataOut  <= 8'h00;
            RxDone     <= 1'b0;
            RxFrameErr <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so only the STOP branch can raise them for one cycle.
            RxDone     <= 1'b0;
            RxFrameErr <= 1'b0;
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (!RxDataIn) begin
                        // With HALF==0 the detecting edge already is the start-bit mid-sample.
                        if (HALF == 0) begin
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            state <= START;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= RxDataIn ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {RxDataIn, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        RxDataOut <= shreg;
                        RxDone    <= 1'b1;
                        if (STOP_CHECK && !RxDataIn) begin
                            RxFrameErr <= 1'b1;
                            state      <= WAIT_HIGH;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line after a bad stop must not look like a fresh start bit.
                    if (RxDataIn) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: three instances (1 clk/bit, 4 clks/bit, 4 clks/bit with
// stop check) share Clock and Reset; each has its own serial line driven by the bench.
module tb_receiver;

    typedef struct {
        int         sel;
        logic [7:0] b;
        logic       err;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] lines = 3'b111;
    logic [7:0] outs [3];
    logic [2:0] done;
    logic [2:0] ferr;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stray = 0;
    ev_t  ev_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    receiver #(.CLKS_PER_BIT(1), .STOP_CHECK(1'b0)) u_c1 (
        .Clock(clk), .Reset(Reset), .RxDataIn(lines[0]),
        .RxDataOut(outs[0]), .RxDone(done[0]), .RxFrameErr(ferr[0]));

    receiver #(.CLKS_PER_BIT(4), .STOP_CHECK(1'b0)) u_c4 (
        .Clock(clk), .Reset(Reset), .RxDataIn(lines[1]),
        .RxDataOut(outs[1]), .RxDone(done[1]), .RxFrameErr(ferr[1]));

    receiver #(.CLKS_PER_BIT(4), .STOP_CHECK(1'b1)) u_c4s (
        .Clock(clk), .Reset(Reset), .RxDataIn(lines[2]),
        .RxDataOut(outs[2]), .RxDone(done[2]), .RxFrameErr(ferr[2]));

    // Record every completion strobe with the posedge count at which it was registered.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (done[s]) ev_q.push_back('{s, outs[s], ferr[s], cyc});
            if (ferr[s] && !done[s]) stray++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            lines = 3'b111;
        end
    endtask

    // k returns the posedge that first samples the start bit.
    task automatic send(input int sel, input int cpb, input logic [7:0] b,
                        input logic stop_bit, output int k);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        k = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                lines[sel] = f[i];
                if (i == 0 && c == 0) k = cyc + 1;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        lines = 3'b111;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle_done cycle %0d: got %b expected 000", i, done);
            end
            checks++;
            if (ferr !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle_ferr cycle %0d: got %b expected 000", i, ferr);
            end
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (outs[s] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_idle_data inst %0d: got %h expected 00", s, outs[s]);
                end
            end
        end
    endtask

    task automatic test_c1_single;
        int k;
        ev_q.delete();
        send(0, 1, 8'hA5, 1'b1, k);
        idle(5);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL c1_single_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].sel != 0 || ev_q[0].b !== 8'hA5) begin
                errors++;
                $display("FAIL c1_single_byte: got inst %0d %h expected inst 0 a5", ev_q[0].sel, ev_q[0].b);
            end
            checks++;
            if (ev_q[0].cyc != k + 9) begin
                errors++;
                $display("FAIL c1_single_latency: got edge %0d expected %0d", ev_q[0].cyc, k + 9);
            end
            checks++;
            if (ev_q[0].err !== 1'b0) begin
                errors++;
                $display("FAIL c1_single_ferr: got %b expected 0", ev_q[0].err);
            end
        end
    endtask

    task automatic test_c1_back_to_back;
        logic [7:0] exp_b [3];
        int         ks [3];
        int         k;
        exp_b = '{8'h00, 8'hFF, 8'h3C};
        ev_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(0, 1, exp_b[i], 1'b1, k);
            ks[i] = k;
        end
        idle(5);
        checks++;
        if (ev_q.size() != 3) begin
            errors++;
            $display("FAIL c1_b2b_count: got %0d expected 3", ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ev_q[i].b !== exp_b[i] || ev_q[i].cyc != ks[i] + 9) begin
                    errors++;
                    $display("FAIL c1_b2b_frame %0d: got %h at %0d expected %h at %0d",
                             i, ev_q[i].b, ev_q[i].cyc, exp_b[i], ks[i] + 9);
                end
            end
        end
    endtask

    task automatic test_c1_stop_ignored;
        int k;
        ev_q.delete();
        send(0, 1, 8'h12, 1'b0, k);
        idle(5);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL c1_stop_low_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].b !== 8'h12 || ev_q[0].err !== 1'b0) begin
                errors++;
                $display("FAIL c1_stop_low_frame: got %h err %b expected 12 err 0", ev_q[0].b, ev_q[0].err);
            end
        end
    endtask

    task automatic test_c4_frame;
        int k;
        ev_q.delete();
        send(1, 4, 8'h5A, 1'b1, k);
        idle(8);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL c4_frame_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].sel != 1 || ev_q[0].b !== 8'h5A || ev_q[0].err !== 1'b0) begin
                errors++;
                $display("FAIL c4_frame_data: got inst %0d %h err %b expected inst 1 5a err 0",
                         ev_q[0].sel, ev_q[0].b, ev_q[0].err);
            end
            checks++;
            if (ev_q[0].cyc != k + 37) begin
                errors++;
                $display("FAIL c4_frame_latency: got edge %0d expected %0d", ev_q[0].cyc, k + 37);
            end
        end
    endtask

    task automatic test_glitch;
        int k;
        ev_q.delete();
        @(negedge clk);
        lines[1] = 1'b0;
        idle(12);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_no_done: got %0d strobes expected 0", ev_q.size());
        end
        send(1, 4, 8'h81, 1'b1, k);
        idle(8);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_then_frame_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].b !== 8'h81 || ev_q[0].cyc != k + 37) begin
                errors++;
                $display("FAIL glitch_then_frame: got %h at %0d expected 81 at %0d",
                         ev_q[0].b, ev_q[0].cyc, k + 37);
            end
        end
    endtask

    task automatic test_frame_err;
        int k;
        ev_q.delete();
        send(2, 4, 8'hC3, 1'b0, k);
        repeat (10) begin
            @(negedge clk);
            lines[2] = 1'b0;
        end
        idle(8);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].sel != 2 || ev_q[0].b !== 8'hC3 || ev_q[0].err !== 1'b1) begin
                errors++;
                $display("FAIL ferr_frame: got inst %0d %h err %b expected inst 2 c3 err 1",
                         ev_q[0].sel, ev_q[0].b, ev_q[0].err);
            end
            checks++;
            if (ev_q[0].cyc != k + 37) begin
                errors++;
                $display("FAIL ferr_latency: got edge %0d expected %0d", ev_q[0].cyc, k + 37);
            end
        end
        ev_q.delete();
        send(2, 4, 8'h11, 1'b1, k);
        idle(8);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL ferr_recover_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].b !== 8'h11 || ev_q[0].err !== 1'b0) begin
                errors++;
                $display("FAIL ferr_recover_frame: got %h err %b expected 11 err 0", ev_q[0].b, ev_q[0].err);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] f;
        int         k;
        f = {1'b1, 8'h99, 1'b0};
        ev_q.delete();
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            lines[1] = f[n / 4];
        end
        @(negedge clk);
        Reset = 1'b1;
        lines = 3'b111;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        idle(40);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: got %0d strobes expected 0", ev_q.size());
        end
        checks++;
        if (outs[1] !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort_data: got %h expected 00", outs[1]);
        end
        send(1, 4, 8'h7E, 1'b1, k);
        idle(8);
        checks++;
        if (ev_q.size() != 1) begin
            errors++;
            $display("FAIL reset_then_frame_count: got %0d expected 1", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0].b !== 8'h7E || outs[1] !== 8'h7E || ev_q[0].cyc != k + 37) begin
                errors++;
                $display("FAIL reset_then_frame: got %h/%h at %0d expected 7e at %0d",
                         ev_q[0].b, outs[1], ev_q[0].cyc, k + 37);
            end
        end
    endtask

    initial begin
        test_reset();
        test_c1_single();
        test_c1_back_to_back();
        test_c1_stop_ignored();
        test_c4_frame();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL ferr_without_done: got %0d cycles expected 0", stray);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
